// File: rtl/alu_seq.sv
// Handshaked ALU execution unit: valid/ready in and out, registered result, sticky overflow.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 1010).
module alu_seq #(
   parameter int DataSize  = 32,
   parameter int ALUopSize = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ALUopSize-1:0] OP,
   input  logic [DataSize-1:0]  src1,
   input  logic [DataSize-1:0]  src2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DataSize-1:0]  alu_result,
   output logic                 Overflow,
   output logic                 ovf_sticky,
   input  logic                 clr_ovf
);

   localparam int ShiftBits = $clog2(DataSize);
   localparam int Msb       = DataSize - 1;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   typedef enum logic [ALUopSize-1:0] {
      OP_ADD = ALUopSize'(0),
      OP_SUB = ALUopSize'(1),
      OP_AND = ALUopSize'(2),
      OP_OR  = ALUopSize'(3),
      OP_SLL = ALUopSize'(4),
      OP_ROT = ALUopSize'(5),
      OP_XOR = ALUopSize'(6),
      OP_SRL = ALUopSize'(7),
      OP_SRA = ALUopSize'(8),
      OP_SLT = ALUopSize'(9),
      OP_MUL = ALUopSize'(10)
   } op_t;

   state_t                  state, state_nx;
   logic                    accept;
   logic                    is_mul;
   logic [DataSize-1:0]     res_c;
   logic                    ovf_c;
   logic [DataSize-1:0]     sum, diff;
   logic [ShiftBits-1:0]    shamt;
   logic                    big;
   logic [2*DataSize-1:0]   rot_w;

   // Single-cycle datapath
   always_comb begin
      sum   = src1 + src2;
      diff  = src1 - src2;
      shamt = src2[ShiftBits-1:0];
      // shift amounts of DataSize or more are detected from the upper src2 bits
      big   = |src2[DataSize-1:ShiftBits];
      rot_w = {src1, src1} >> shamt;
      res_c = '0;
      ovf_c = 1'b0;
      case (op_t'(OP))
         OP_ADD: begin
            res_c = sum;
            ovf_c = (src1[Msb] == src2[Msb]) && (sum[Msb] != src1[Msb]);
         end
         OP_SUB: begin
            res_c = diff;
            ovf_c = (src1[Msb] != src2[Msb]) && (diff[Msb] != src1[Msb]);
         end
         OP_AND: res_c = src1 & src2;
         OP_OR:  res_c = src1 | src2;
         OP_XOR: res_c = src1 ^ src2;
         OP_SLL: res_c = big ? '0 : (src1 << shamt);
         OP_SRL: res_c = big ? '0 : (src1 >> shamt);
         OP_SRA: res_c = big ? {DataSize{src1[Msb]}} : $unsigned($signed(src1) >>> shamt);
         OP_ROT: res_c = rot_w[DataSize-1:0];
         OP_SLT: res_c = {{(DataSize-1){1'b0}}, ($signed(src1) < $signed(src2))};
         default: begin
            res_c = '0;
            ovf_c = 1'b0;
         end
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   logic [DataSize-1:0]  mcand;
   logic [DataSize-1:0]  mul_hi, mul_lo;
   logic [ShiftBits-1:0] cnt;
   logic [DataSize:0]    mul_sum;
   logic [DataSize-1:0]  step_hi, step_lo;
   logic                 last_step;

   assign is_mul = (op_t'(OP) == OP_MUL);

   // One radix-2 step: conditionally add multiplicand to the high half, then shift {carry,hi,lo} right
   always_comb begin
      mul_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : '0);
      step_hi   = mul_sum[DataSize:1];
      step_lo   = {mul_sum[0], mul_lo[DataSize-1:1]};
      last_step = (cnt == '1);
   end
`else
   assign is_mul = 1'b0;
`endif

   // Next-state and handshake
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      in_ready = in_ready & rst_n;
      accept   = in_valid & in_ready;
      case (state)
         IDLE: begin
            if (accept) state_nx = is_mul ? EXEC : DONE;
         end
         DONE: begin
            if (out_ready) begin
               if (accept) state_nx = is_mul ? EXEC : DONE;
               else        state_nx = IDLE;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         EXEC: begin
            if (last_step) state_nx = DONE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         out_valid <= (state_nx == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result <= '0;
         Overflow   <= 1'b0;
      end else if (accept && !is_mul) begin
         alu_result <= res_c;
         Overflow   <= ovf_c;
`ifdef ALU_SEQ_MUL_EN
      end else if (state == EXEC && last_step) begin
         alu_result <= step_lo;
         Overflow   <= |step_hi;
`endif
      end
   end

`ifdef ALU_SEQ_MUL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mul_hi <= '0;
         mul_lo <= '0;
         cnt    <= '0;
      end else if (accept && is_mul) begin
         mcand  <= src1;
         mul_hi <= '0;
         mul_lo <= src2;
         cnt    <= '0;
      end else if (state == EXEC) begin
         mul_hi <= step_hi;
         mul_lo <= step_lo;
         cnt    <= cnt + 1'b1;
      end
   end
`endif

   // Set has priority over a coincident clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              ovf_sticky <= 1'b0;
      else if (out_valid && out_ready && Overflow) ovf_sticky <= 1'b1;
      else if (clr_ovf)                        ovf_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (DataSize=32); MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  OP = '0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] alu_result;
   logic        Overflow;
   logic        ovf_sticky;
   logic        clr_ovf = 1'b0;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   pops_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   alu_seq #(.DataSize(32), .ALUopSize(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .OP         (OP),
      .src1       (src1),
      .src2       (src2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_result (alu_result),
      .Overflow   (Overflow),
      .ovf_sticky (ovf_sticky),
      .clr_ovf    (clr_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL result_unexpected got=%h ovf=%b expected none", alu_result, Overflow);
         end else begin
            e = exp_q.pop_front();
            if ({alu_result, Overflow} !== {e.res, e.ovf}) begin
               fails++;
               $display("FAIL result got=%h ovf=%b expected=%h ovf=%b", alu_result, Overflow, e.res, e.ovf);
            end
         end
         pops_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eo);
      int n = 0;
      OP = op; src1 = a; src2 = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!in_ready) begin
         fails++;
         $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      end else begin
         exp_q.push_back('{er, eo});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if ({out_valid, alu_result, Overflow, ovf_sticky, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state vld=%b res=%h ovf=%b sticky=%b rdy=%b required all 0",
                  out_valid, alu_result, Overflow, ovf_sticky, in_ready);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready got=%b required=1", in_ready);
      end
   endtask

   task automatic test_add_ovf();
      int lat;
      out_ready = 1'b1;
      send(4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
      wait_valid(lat);
      tests++;
      if (lat != 1) begin
         fails++;
         $display("FAIL add_latency got=%0d required=1", lat);
      end
      @(posedge clk); #1;
      tests++;
      if (ovf_sticky !== 1'b1) begin
         fails++;
         $display("FAIL add_sticky got=%b required=1", ovf_sticky);
      end
      drain();
   endtask

   task automatic test_shifts();
      out_ready = 1'b1;
      send(4'h5, 32'h1,         32'd33, 32'h8000_0000, 1'b0);
      send(4'h8, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0);
      send(4'h4, 32'h1,         32'd32, 32'h0,         1'b0);
      send(4'h9, 32'hFFFF_FFFF, 32'h1,  32'h1,         1'b0);
      send(4'h9, 32'h1, 32'hFFFF_FFFF,  32'h0,         1'b0);
      send(4'h7, 32'h8000_0000, 32'd31, 32'h1,         1'b0);
      send(4'h8, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1'b0);
      send(4'h5, 32'h0000_00F1, 32'd4,  32'h1000_000F, 1'b0);
      send(4'h1, 32'h8000_0000, 32'h1,  32'h7FFF_FFFF, 1'b1);
      send(4'h1, 32'd5,         32'd7,  32'hFFFF_FFFE, 1'b0);
      send(4'h2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0);
      send(4'h3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0);
      send(4'hF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b0);
      drain();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, held;
      a = $urandom; b = $urandom;
      held = a ^ b;
      out_ready = 1'b0;
      send(4'h6, a, b, held, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if ({out_valid, alu_result, in_ready} !== {1'b1, held, 1'b0}) begin
            fails++;
            $display("FAIL stall_hold vld=%b res=%h rdy=%b required vld=1 res=%h rdy=0",
                     out_valid, alu_result, in_ready, held);
         end
         @(posedge clk); #1;
      end
      pops_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom;
         send(4'h6, a, b, a ^ b, 1'b0);
      end
      drain();
      tests++;
      if (pops_q.size() != 5) begin
         fails++;
         $display("FAIL b2b_count got=%0d required=5", pops_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (pops_q[i+1] - pops_q[i] != 1) begin
               fails++;
               $display("FAIL b2b_gap idx=%0d got=%0d required=1", i, pops_q[i+1] - pops_q[i]);
            end
         end
      end
   endtask

   task automatic test_mul();
      int lat;
      out_ready = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      send(4'hA, 32'd7, 32'd6, 32'd42, 1'b0);
      wait_valid(lat);
      tests++;
      if (lat != 33) begin
         fails++;
         $display("FAIL mul_latency_a got=%0d required=33", lat);
      end
      drain();
      send(4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
      wait_valid(lat);
      tests++;
      if (lat != 33) begin
         fails++;
         $display("FAIL mul_latency_b got=%0d required=33", lat);
      end
      drain();
      send(4'hA, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b1);
      drain();
`else
      send(4'hA, 32'd7, 32'd6, 32'h0, 1'b0);
      wait_valid(lat);
      tests++;
      if (lat != 1) begin
         fails++;
         $display("FAIL mul_undef_latency got=%0d required=1", lat);
      end
      drain();
`endif
   endtask

   task automatic test_reset_mid_op();
`ifdef ALU_SEQ_MUL_EN
      out_ready = 1'b1;
      send(4'hA, 32'd3, 32'd5, 32'd15, 1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
`else
      out_ready = 1'b0;
      send(4'h0, 32'd9, 32'd9, 32'd18, 1'b0);
      @(posedge clk); #1;
`endif
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      tests++;
      if ({out_valid, in_ready} !== 2'b00) begin
         fails++;
         $display("FAIL midop_reset vld=%b rdy=%b required 0 0", out_valid, in_ready);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         fails++;
         $display("FAIL midop_release rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
      end
      out_ready = 1'b1;
      send(4'h0, 32'd2, 32'd3, 32'd5, 1'b0);
      drain();
   endtask

   task automatic test_sticky();
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      tests++;
      if (ovf_sticky !== 1'b0) begin
         fails++;
         $display("FAIL sticky_clear got=%b required=0", ovf_sticky);
      end
      out_ready = 1'b0;
      send(4'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1);
      @(posedge clk); #1;
      tests++;
      if (ovf_sticky !== 1'b0) begin
         fails++;
         $display("FAIL sticky_no_transfer got=%b required=0", ovf_sticky);
      end
      clr_ovf   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (ovf_sticky !== 1'b1) begin
         fails++;
         $display("FAIL sticky_set_wins got=%b required=1", ovf_sticky);
      end
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      tests++;
      if (ovf_sticky !== 1'b0) begin
         fails++;
         $display("FAIL sticky_clear_after got=%b required=0", ovf_sticky);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_add_ovf();
      test_shifts();
      test_back_to_back();
      test_mul();
      test_reset_mid_op();
      test_sticky();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
